// File: rtl/faller.sv
// Falling-block generator: spawns one block at a time, drops it on a divided tick,
// retires it on a catch and tracks misses. `FALLER_SPEEDUP_EN adds catch-based speedup.
module faller #(
    parameter int          DIV_W     = 18,
    parameter int          STEP      = 2,
    parameter int          FLOOR_Y   = 480,
    parameter int          SPAWN_Y   = 0,
    parameter int          GAP_TICKS = 32,
    parameter int          X_MIN     = 40,
    parameter int          MAX_MISS  = 3,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pause,
    input  logic       collision,
    output logic [9:0] fall_x,
    output logic [9:0] fall_y,
    output logic [1:0] fall_color,
    output logic       active,
    output logic [1:0] misses,
    output logic [7:0] caught,
    output logic       game_over
);

    typedef enum logic [1:0] {
        ST_GAP  = 2'd0,
        ST_FALL = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_TICKS - 1);
    localparam logic [10:0]      FLOOR_LIM = 11'(FLOOR_Y);
    localparam logic [9:0]       HIDDEN_Y  = 10'h3FF;

    state_t             state;
    logic [GAP_W-1:0]   gap_cnt;
    logic [DIV_W-1:0]   div_cnt;
    logic [15:0]        lfsr;
    logic               lfsr_fb;
    logic               tick;
    logic [10:0]        step_amt;
    logic [10:0]        y_next;
    logic [2:0]         miss_next;
    logic [9:0]         spawn_x;
    logic [1:0]         spawn_color;

    assign tick    = (div_cnt == '0) && !pause;
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_comb begin
        step_amt = 11'(STEP);
`ifdef FALLER_SPEEDUP_EN
        // One extra pixel per four catches, capped at three extra.
        if (caught[7:2] >= 6'd3) begin
            step_amt = 11'(STEP + 3);
        end else begin
            step_amt = 11'(STEP) + {9'd0, caught[3:2]};
        end
`endif
    end

    assign y_next      = {1'b0, fall_y} + step_amt;
    assign miss_next   = {1'b0, misses} + 3'd1;
    assign spawn_x     = 10'(X_MIN) + {1'b0, lfsr[8:0]};
    assign spawn_color = (lfsr[10:9] == 2'b00) ? 2'b01 : lfsr[10:9];

    // The LFSR free-runs so spawn positions depend on how long play took.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (!pause) begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_GAP;
            gap_cnt    <= '0;
            fall_x     <= '0;
            fall_y     <= HIDDEN_Y;
            fall_color <= '0;
            active     <= 1'b0;
            misses     <= '0;
            caught     <= '0;
            game_over  <= 1'b0;
        end else begin
            case (state)
                ST_GAP: begin
                    if (tick) begin
                        if (gap_cnt == GAP_LAST) begin
                            state      <= ST_FALL;
                            gap_cnt    <= '0;
                            fall_x     <= spawn_x;
                            fall_y     <= 10'(SPAWN_Y);
                            fall_color <= spawn_color;
                            active     <= 1'b1;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                end

                ST_FALL: begin
                    // A catch wins over a tick landing in the same cycle.
                    if (collision) begin
                        if (caught != 8'hFF) begin
                            caught <= caught + 8'd1;
                        end
                        state      <= ST_GAP;
                        active     <= 1'b0;
                        fall_y     <= HIDDEN_Y;
                        fall_color <= '0;
                    end else if (tick) begin
                        if (y_next >= FLOOR_LIM) begin
                            misses     <= miss_next[1:0];
                            active     <= 1'b0;
                            fall_y     <= HIDDEN_Y;
                            fall_color <= '0;
                            if (miss_next == 3'(MAX_MISS)) begin
                                state     <= ST_OVER;
                                game_over <= 1'b1;
                            end else begin
                                state <= ST_GAP;
                            end
                        end else begin
                            fall_y <= y_next[9:0];
                        end
                    end
                end

                ST_OVER: begin
                    active     <= 1'b0;
                    fall_y     <= HIDDEN_Y;
                    fall_color <= '0;
                    game_over  <= 1'b1;
                end

                default: begin
                    state <= ST_GAP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_faller.sv
// Bench for faller: directed vector table, hand-written corner sequences and a
// randomized run checked every cycle against a behavioural model.
module tb_faller;

    localparam int DIV_W     = 2;
    localparam int GAP_TICKS = 2;
    localparam int STEP      = 2;
    localparam int FLOOR_Y   = 480;
    localparam int SPAWN_Y   = 0;
    localparam int X_MIN     = 40;
    localparam int MAX_MISS  = 3;
    localparam int M_GAP     = 0;
    localparam int M_FALL    = 1;
    localparam int M_OVER    = 2;

    logic       clk;
    logic       rst;
    logic       pause;
    logic       collision;
    logic [9:0] fall_x;
    logic [9:0] fall_y;
    logic [1:0] fall_color;
    logic       active;
    logic [1:0] misses;
    logic [7:0] caught;
    logic       game_over;

    int tests;
    int fails;

    // behavioural model state
    int m_lfsr, m_div, m_mode, m_gap;
    int m_x, m_y, m_color, m_active, m_misses, m_caught, m_over;

    typedef struct {
        int cycles;
        bit pause;
        bit coll;
        int exp_active;
        int exp_y;
        int exp_caught;
        int exp_misses;
        int exp_over;
    } vec_t;

    vec_t vecs[10];

    faller #(
        .DIV_W(DIV_W),
        .GAP_TICKS(GAP_TICKS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pause(pause),
        .collision(collision),
        .fall_x(fall_x),
        .fall_y(fall_y),
        .fall_color(fall_color),
        .active(active),
        .misses(misses),
        .caught(caught),
        .game_over(game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_lfsr = 16'hACE1; m_div = 0; m_mode = M_GAP; m_gap = 0;
        m_x = 0; m_y = 1023; m_color = 0; m_active = 0;
        m_misses = 0; m_caught = 0; m_over = 0;
    endtask

    function automatic int model_step();
`ifdef FALLER_SPEEDUP_EN
        return STEP + ((m_caught / 4 < 3) ? m_caught / 4 : 3);
`else
        return STEP;
`endif
    endfunction

    task automatic model_hide();
        m_active = 0; m_y = 1023; m_color = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_cycle();
        bit tk;
        int ny;
        int fb;
        tk = (m_div == 0) && !pause;
        if (!pause) m_div = (m_div + 1) % (1 << DIV_W);
        if (m_mode == M_GAP) begin
            if (tk) begin
                if (m_gap == GAP_TICKS - 1) begin
                    m_mode = M_FALL; m_gap = 0; m_active = 1; m_y = SPAWN_Y;
                    m_x = X_MIN + (m_lfsr % 512);
                    m_color = (m_lfsr / 512) % 4;
                    if (m_color == 0) m_color = 1;
                end else begin
                    m_gap++;
                end
            end
        end else if (m_mode == M_FALL) begin
            if (collision) begin
                m_caught = (m_caught < 255) ? m_caught + 1 : 255;
                model_hide();
                m_mode = M_GAP;
            end else if (tk) begin
                ny = m_y + model_step();
                if (ny >= FLOOR_Y) begin
                    m_misses++;
                    model_hide();
                    if (m_misses == MAX_MISS) begin
                        m_mode = M_OVER; m_over = 1;
                    end else begin
                        m_mode = M_GAP;
                    end
                end else begin
                    m_y = ny;
                end
            end
        end
        fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
        m_lfsr = ((m_lfsr << 1) | fb) & 16'hFFFF;
    endtask

    task automatic step();
        logic [33:0] act_v, exp_v;
        model_cycle();
        @(posedge clk);
        #1;
        act_v = {active, fall_y, fall_color, misses, caught, game_over,
                 (m_active != 0) ? fall_x : 10'd0};
        exp_v = {m_active[0], m_y[9:0], m_color[1:0], m_misses[1:0], m_caught[7:0],
                 m_over[0], (m_active != 0) ? m_x[9:0] : 10'd0};
        chk("cycle", act_v, exp_v);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_x"}, fall_x, 0);
        chk({tag, "_y"}, fall_y, 10'h3FF);
        chk({tag, "_color"}, fall_color, 0);
        chk({tag, "_active"}, active, 0);
        chk({tag, "_misses"}, misses, 0);
        chk({tag, "_caught"}, caught, 0);
        chk({tag, "_over"}, game_over, 0);
    endtask

    task automatic wait_fall(input string name);
        int n;
        n = 0;
        while (m_mode != M_FALL && n < 200) begin
            step();
            n++;
        end
        chk(name, (n < 200) ? 1 : 0, 1);
    endtask

    task automatic catch_blocks(input int count);
        for (int i = 0; i < count; i++) begin
            wait_fall("catch_wait");
            collision = 1'b1;
            step();
            collision = 1'b0;
        end
    endtask

    task automatic first_drop(input string name, input int exp_y);
        int n;
        wait_fall("drop_wait");
        n = 0;
        while (m_y == SPAWN_Y && m_mode == M_FALL && n < 50) begin
            step();
            n++;
        end
        chk(name, fall_y, exp_y);
    endtask

    initial begin
        int n;
        tests = 0;
        fails = 0;
        rst = 1'b0;
        pause = 1'b0;
        collision = 1'b0;
        model_reset();

        vecs[0] = '{4,   0, 0, 0, 1023, 0, 0, 0};
        vecs[1] = '{1,   0, 0, 1, 0,    0, 0, 0};
        vecs[2] = '{4,   0, 0, 1, 2,    0, 0, 0};
        vecs[3] = '{10,  1, 0, 1, 2,    0, 0, 0};
        vecs[4] = '{3,   0, 0, 1, 2,    0, 0, 0};
        vecs[5] = '{1,   0, 0, 1, 4,    0, 0, 0};
        vecs[6] = '{192, 0, 0, 1, 100,  0, 0, 0};
        vecs[7] = '{1,   0, 1, 0, 1023, 1, 0, 0};
        vecs[8] = '{5,   0, 1, 0, 1023, 1, 0, 0};
        vecs[9] = '{2,   0, 0, 1, 0,    1, 0, 0};

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b1;

        for (int v = 0; v < 10; v++) begin
            pause = vecs[v].pause;
            collision = vecs[v].coll;
            for (int c = 0; c < vecs[v].cycles; c++) step();
            chk($sformatf("vec%0d_active", v), active, vecs[v].exp_active);
            chk($sformatf("vec%0d_y", v), fall_y, vecs[v].exp_y);
            chk($sformatf("vec%0d_caught", v), caught, vecs[v].exp_caught);
            chk($sformatf("vec%0d_misses", v), misses, vecs[v].exp_misses);
            chk($sformatf("vec%0d_over", v), game_over, vecs[v].exp_over);
            if (vecs[v].exp_active != 0) begin
                chk($sformatf("vec%0d_color_nz", v), (fall_color != 0) ? 1 : 0, 1);
                chk($sformatf("vec%0d_x_range", v),
                    (fall_x >= 10'd40 && fall_x <= 10'd551) ? 1 : 0, 1);
            end
        end
        pause = 1'b0;
        collision = 1'b0;

        // catch and tick coincide at the last on-screen row
        n = 0;
        while (!(m_mode == M_FALL && m_y == 478 && m_div == 0) && n < 3000) begin
            step();
            n++;
        end
        chk("reach_478", (n < 3000) ? 1 : 0, 1);
        chk("at_478_y", fall_y, 478);
        collision = 1'b1;
        step();
        collision = 1'b0;
        chk("edge_catch_caught", caught, 2);
        chk("edge_catch_misses", misses, 0);
        chk("edge_catch_active", active, 0);

        // three uncaught blocks end the game
        n = 0;
        while (m_mode != M_OVER && n < 4000) begin
            step();
            n++;
        end
        chk("reach_over", (n < 4000) ? 1 : 0, 1);
        chk("over_flag", game_over, 1);
        chk("over_misses", misses, 3);
        for (int i = 0; i < 40; i++) begin
            pause = ($urandom_range(0, 1) == 1);
            collision = ($urandom_range(0, 1) == 1);
            step();
        end
        pause = 1'b0;
        collision = 1'b0;
        chk("over_sticky", game_over, 1);
        chk("over_caught", caught, 2);
        chk("over_y", fall_y, 10'h3FF);

        // asynchronous reset between clock edges
        #2 rst = 1'b0;
        #1 check_reset_values("midreset");
        model_reset();
        @(negedge clk);
        rst = 1'b1;

`ifdef FALLER_SPEEDUP_EN
        catch_blocks(4);
        first_drop("speed_after_4", 3);
        catch_blocks(8);
        first_drop("speed_after_12", 5);
        catch_blocks(4);
        first_drop("speed_after_16", 5);
`endif

        for (int i = 0; i < 3000; i++) begin
            pause = ($urandom_range(0, 7) == 0);
            collision = ($urandom_range(0, 29) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/faller.md
Name: faller

Overview:
- Upstream of the stack stage. Spawns one falling block at a time at a pseudo-random x with a pseudo-random non-zero colour.
- Drops the block toward the floor on a divided tick and drives fall_x/fall_y/fall_color into the stack.
- Retires the block when the stack reports a catch (collision). Counts blocks that reach the floor uncaught and asserts game_over after too many misses.

Parameters:
- DIV_W, 18: width of the fall-tick divider; one tick each time the divider wraps to 0.
- STEP, 2: pixels fall_y advances per tick.
- FLOOR_Y, 480: fall_y at or beyond this value is a miss.
- SPAWN_Y, 0: fall_y of a newly spawned block.
- GAP_TICKS, 32: ticks spent in GAP between blocks.
- X_MIN, 40: offset added to the random x, giving x range X_MIN..X_MIN+511.
- MAX_MISS, 3: miss count that causes game_over.
- SEED, 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-low reset (asserted at 0).
- pause, input, 1: when 1, the divider, the falling motion and the GAP countdown freeze. LFSR keeps running.
- collision, input, 1: catch indication from the stack, sampled every cycle.
- fall_x, output, 10: block x (top-left).
- fall_y, output, 10: block y (top-left); 10'h3FF when no block is active.
- fall_color, output, 2: block colour, never 0 while active; 0 when inactive.
- active, output, 1: a block is in flight.
- misses, output, 2: number of blocks that reached the floor, saturating.
- caught, output, 8: number of blocks caught, saturating at 255.
- game_over, output, 1: sticky until reset.

Behaviour:
- Reset values: state=GAP, gap counter=0, divider=0, LFSR=SEED. Outputs: fall_x=0, fall_y=10'h3FF, fall_color=0, active=0, misses=0, caught=0, game_over=0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle out of reset, regardless of pause or state.
- Divider: DIV_W-bit counter, increments each cycle when pause=0. tick = (divider==0) & ~pause.
- States are GAP, FALL and OVER. All outputs are registered.
- GAP:
  - active=0, fall_y=3FF, fall_color=0.
  - On each tick the gap counter increments.
  - When gap counter==GAP_TICKS-1 and a tick occurs, the next cycle is FALL with:
    - fall_x = X_MIN + lfsr[8:0]
    - fall_y = SPAWN_Y
    - fall_color = lfsr[10:9], with 0 remapped to 1
    - active=1, gap counter cleared.
- FALL, priority order within one cycle:
  - (1) collision=1: caught++, go to GAP, fall_y=3FF and colour=0 on the next cycle. A tick in the same cycle is ignored.
  - (2) else on tick: if fall_y+STEP >= FLOOR_Y, misses++; then go to OVER if the new count equals MAX_MISS, otherwise go to GAP. Output is hidden as in GAP. Otherwise fall_y += STEP.
  - Adder is 11 bits wide, so no 10-bit wrap.
- collision while not in FALL is ignored. The stack may hold collision high for several cycles; only the first cycle in FALL counts.
- OVER: active=0, game_over=1, fall_y=3FF. Ignores all inputs; only reset leaves this state.
- pause=1 mid-fall: fall_y holds and the block stays active. A collision still counts, because the block can be hit by the moving stack only when unpaused, but the check is not gated.
- Reset mid-operation: returns immediately (asynchronously) to the reset values above.
- Saturation: caught stops at 255; misses cannot exceed MAX_MISS.

Optional Feature:
- Macro: FALLER_SPEEDUP_EN.
- When defined: effective step = STEP + min(caught[7:2], 3), re-evaluated on every tick. The block speeds up by 1 px/tick per 4 catches, capped at STEP+3.
- When undefined: step is always STEP. The caught counter remains, but has no effect on motion.

Test Plan:
- Reset release with DIV_W=2, GAP_TICKS=2: idle until the spawn, then active=1, fall_y=0, fall_color≠0, fall_x in 40..551. While idle, fall_y=3FF.
- Free fall, no collision, STEP=2, FLOOR_Y=480: fall_y runs 0,2,...,478, one step per tick. Then the next tick gives misses=1, active=0, fall_y=3FF, and a new spawn after GAP.
- Pulse collision at fall_y=100: next cycle caught=1, active=0, fall_y=3FF. Hold collision for 5 cycles: caught stays 1.
- Collision and tick in the same cycle at fall_y=478: counted as a catch (caught=1, misses unchanged), not a miss.
- Let 3 blocks fall uncaught: game_over=1 after the third. Collision and pause afterwards change nothing. Pulse rst low: all outputs return to reset values.
- With FALLER_SPEEDUP_EN defined and 4 catches: the fifth block advances 3 px/tick. After 12 catches: 5 px/tick, which stays capped.
